// File: rtl/f1_start_seq.sv
// F1-style start-lamp sequencer with random hold and reaction-time measurement.
//
// A trigger press in IDLE starts the lamp sequence. Each tick lights one more
// lamp. Once all lamps are lit they stay lit for a pseudo-random number of
// ticks, taken from a free-running LFSR. When they go out, the block counts
// ticks until the next press and reports that count. A press while the lamps
// are held is a false start.
//
// Ports:
//   clk          single clock, all state on posedge
//   rst          asynchronous active-high reset
//   tick         one-cycle time-base enable from the upstream divider
//   trigger      start/reaction button (level, synchronous)
//   cmd_seq      high while lamps are sequencing or held (divider enable)
//   data_out     lamp drive, bit 0 lights first
//   react_time   last measured reaction time in ticks
//   react_valid  one-cycle pulse when react_time updates
//   false_start  one-cycle pulse on a press while lamps are held
module f1_start_seq #(
  parameter int unsigned N_LIGHTS = 8,
  parameter int unsigned LFSR_W   = 7,
  parameter int unsigned RT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                trigger,
  output logic                cmd_seq,
  output logic [N_LIGHTS-1:0] data_out,
  output logic [RT_W-1:0]     react_time,
  output logic                react_valid,
  output logic                false_start
);

  localparam logic [LFSR_W-1:0] HoldOne = {{(LFSR_W-1){1'b0}}, 1'b1};
  localparam logic [RT_W-1:0]   RtOne   = {{(RT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StLight, StHold, StReact} state_e;

  state_e              state_q, state_d;
  logic [N_LIGHTS-1:0] lamps_q, lamps_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [LFSR_W-1:0]   hold_q, hold_d;
  logic [RT_W-1:0]     rt_q, rt_d;
  logic [RT_W-1:0]     rtime_q, rtime_d;
  logic                trig_q;
  logic                press;
  logic                rv_q, rv_d;
  logic                fs_q, fs_d;
  logic                cmd_q, cmd_d;

  // Rising edge of the button; a held button counts as one press.
  assign press = trigger & ~trig_q;

  // x^7 + x^3 + 1, shift-left Fibonacci form; never reaches zero from a
  // non-zero seed.
  assign lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_W-1] ^ lfsr_q[2]};

  always_comb begin
    state_d = state_q;
    lamps_d = lamps_q;
    hold_d  = hold_q;
    rt_d    = rt_q;
    rtime_d = rtime_q;
    rv_d    = 1'b0;
    fs_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (press) begin
          state_d = StLight;
          lamps_d = '0;
        end
      end
      StLight: begin
        if (tick) begin
          lamps_d = {lamps_q[N_LIGHTS-2:0], 1'b1};
          // This tick lights the last lamp.
          if (&lamps_q[N_LIGHTS-2:0]) begin
            state_d = StHold;
            hold_d  = lfsr_q;
          end
        end
      end
      StHold: begin
        // A press wins over a coincident tick.
        if (press) begin
          state_d = StIdle;
          lamps_d = '0;
          fs_d    = 1'b1;
        end else if (tick) begin
          if (hold_q == HoldOne) begin
            state_d = StReact;
            lamps_d = '0;
            rt_d    = '0;
          end else if (hold_q != '0) begin
            hold_d = hold_q - HoldOne;
          end
        end
      end
      StReact: begin
        // Captures the pre-increment count when a tick coincides.
        if (press) begin
          state_d = StIdle;
          rtime_d = rt_q;
          rv_d    = 1'b1;
        end else if (tick && (rt_q != '1)) begin
          rt_d = rt_q + RtOne;
        end
      end
      default: state_d = StIdle;
    endcase
    cmd_d = (state_d == StLight) || (state_d == StHold);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      lamps_q <= '0;
      lfsr_q  <= HoldOne;
      hold_q  <= '0;
      rt_q    <= '0;
      rtime_q <= '0;
      trig_q  <= 1'b0;
      rv_q    <= 1'b0;
      fs_q    <= 1'b0;
      cmd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lamps_q <= lamps_d;
      lfsr_q  <= lfsr_d;
      hold_q  <= hold_d;
      rt_q    <= rt_d;
      rtime_q <= rtime_d;
      trig_q  <= trigger;
      rv_q    <= rv_d;
      fs_q    <= fs_d;
      cmd_q   <= cmd_d;
    end
  end

  assign cmd_seq     = cmd_q;
  assign data_out    = lamps_q;
  assign react_time  = rtime_q;
  assign react_valid = rv_q;
  assign false_start = fs_q;

endmodule

// File: tb/tb_f1_start_seq.sv
// Self-checking bench for f1_start_seq: table-driven lamp vectors, hand-written
// multi-cycle sequences, and a scoreboard for react_valid/false_start events.
module tb_f1_start_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        trigger = 1'b0;
  logic        cmd_seq;
  logic [7:0]  data_out;
  logic [15:0] react_time;
  logic        react_valid;
  logic        false_start;

  int checks = 0;
  int failures = 0;

  f1_start_seq #(
    .N_LIGHTS(8),
    .LFSR_W  (7),
    .RT_W    (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .trigger    (trigger),
    .cmd_seq    (cmd_seq),
    .data_out   (data_out),
    .react_time (react_time),
    .react_valid(react_valid),
    .false_start(false_start)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^7+x^3+1, seeded with 1, advancing every clock.
  logic [6:0] lfsr_m, lfsr_prev;

  function automatic logic [6:0] lstep(input logic [6:0] v);
    return {v[5:0], v[6] ^ v[2]};
  endfunction

  function automatic logic [6:0] stepn(input logic [6:0] v, input int n);
    logic [6:0] r = v;
    for (int i = 0; i < n; i++) r = lstep(r);
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_m    <= 7'd1;
      lfsr_prev <= 7'd1;
    end else begin
      lfsr_prev <= lfsr_m;
      lfsr_m    <= lstep(lfsr_m);
    end
  end

  // Scoreboard of expected pulse events.
  typedef struct {
    logic        fs;
    logic [15:0] rt;
  } ev_t;
  ev_t sbq[$];
  ev_t ev;

  always @(negedge clk) begin
    if (!rst) begin
      if (react_valid && false_start) begin
        checks++;
        failures++;
        $display("FAIL pulse_overlap react_valid=%0b false_start=%0b required not both",
                 react_valid, false_start);
      end else if (react_valid || false_start) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse react_valid=%0b false_start=%0b required none",
                   react_valid, false_start);
        end else begin
          ev = sbq.pop_front();
          if (ev.fs !== false_start || (!ev.fs && react_time !== ev.rt)) begin
            failures++;
            $display("FAIL sb_event actual fs=%0b rt=%0d required fs=%0b rt=%0d",
                     false_start, react_time, ev.fs, ev.rt);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic t, input logic tr);
    tick    = t;
    trigger = tr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_ev(input logic fs, input logic [15:0] rt);
    ev_t e;
    e.fs = fs;
    e.rt = rt;
    sbq.push_back(e);
  endtask

  // Walk a hold of h ticks, one tick every gap clocks; lamps drop on the h-th.
  task automatic hold_phase(input int h, input int gap, input logic tr);
    for (int k = 1; k <= h; k++) begin
      repeat (gap - 1) cyc(1'b0, tr);
      cyc(1'b1, tr);
      chk("hold_lamps", {24'd0, data_out}, (k < h) ? 32'hFF : 32'h00);
      chk("hold_cmd", {31'd0, cmd_seq}, (k < h) ? 32'd1 : 32'd0);
    end
  endtask

  typedef struct {
    logic       tk;
    logic       tr;
    logic [7:0] d;
    logic       cs;
  } vec_t;
  vec_t tbl[13];

  int c;
  int h;
  int w;

  initial begin
    // tick, trigger, expected lamps, expected cmd_seq (after the edge)
    tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b0};  // tick in IDLE ignored
    tbl[2]  = '{1'b1, 1'b1, 8'h00, 1'b1};  // press with tick: tick not counted
    tbl[3]  = '{1'b0, 1'b1, 8'h00, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 8'h01, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 8'h01, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 8'h03, 1'b1};  // press in LIGHT ignored
    tbl[7]  = '{1'b1, 1'b0, 8'h07, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 8'h0F, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 8'h1F, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 8'h3F, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 8'h7F, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 8'hFF, 1'b1};

    // Reset state
    repeat (3) cyc(1'b0, 1'b0);
    chk("rst_data", {24'd0, data_out}, 32'd0);
    chk("rst_cmd", {31'd0, cmd_seq}, 32'd0);
    chk("rst_rtime", {16'd0, react_time}, 32'd0);
    chk("rst_rv", {31'd0, react_valid}, 32'd0);
    chk("rst_fs", {31'd0, false_start}, 32'd0);
    rst = 1'b0;

    // Tick every 4 clocks, press at cycle 10
    for (c = 1; c <= 9; c++) cyc(c % 4 == 0, 1'b0);
    chk("idle_data", {24'd0, data_out}, 32'd0);
    chk("idle_cmd", {31'd0, cmd_seq}, 32'd0);
    cyc(1'b0, 1'b1);
    chk("press_cmd", {31'd0, cmd_seq}, 32'd1);
    chk("press_data", {24'd0, data_out}, 32'd0);
    for (int i = 1; i <= 8; i++) begin
      c++;
      while (c % 4 != 0) begin
        cyc(1'b0, 1'b0);
        c++;
      end
      cyc(1'b1, 1'b0);
      chk("lamp_seq", {24'd0, data_out}, (32'd1 << i) - 32'd1);
      chk("lamp_cmd", {31'd0, cmd_seq}, 32'd1);
    end
    h = int'(lfsr_prev);
    hold_phase(h, 4, 1'b0);

    // 37 ticks in REACT, then a press coincident with a tick
    push_ev(1'b0, 16'd37);
    repeat (37) begin
      repeat (3) cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
    end
    cyc(1'b1, 1'b1);
    chk("react_end_data", {24'd0, data_out}, 32'd0);
    chk("react_end_cmd", {31'd0, cmd_seq}, 32'd0);
    repeat (4) cyc(1'b1, 1'b1);
    chk("no_restart_cmd", {31'd0, cmd_seq}, 32'd0);
    chk("no_restart_data", {24'd0, data_out}, 32'd0);
    cyc(1'b0, 1'b0);

    // Align so the LFSR value captured at HOLD entry is 5
    w = 0;
    while (stepn(lfsr_m, 12) != 7'd5 && w < 200) begin
      cyc(1'b0, 1'b0);
      w++;
    end
    chk("lfsr_align_bound", (w < 200) ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].tk, tbl[i].tr);
      chk($sformatf("vec%0d_data", i), {24'd0, data_out}, {24'd0, tbl[i].d});
      chk($sformatf("vec%0d_cmd", i), {31'd0, cmd_seq}, {31'd0, tbl[i].cs});
    end
    hold_phase(5, 1, 1'b0);

    // Immediate press in REACT reports zero
    push_ev(1'b0, 16'd0);
    cyc(1'b0, 1'b1);
    chk("react0_cmd", {31'd0, cmd_seq}, 32'd0);
    cyc(1'b0, 1'b0);

    // False start: press during HOLD coincident with a tick
    cyc(1'b0, 1'b1);
    repeat (8) cyc(1'b1, 1'b0);
    chk("fs_hold_data", {24'd0, data_out}, 32'hFF);
    push_ev(1'b1, 16'd0);
    cyc(1'b1, 1'b1);
    chk("fs_data", {24'd0, data_out}, 32'd0);
    chk("fs_cmd", {31'd0, cmd_seq}, 32'd0);
    cyc(1'b1, 1'b1);
    chk("fs_idle_data", {24'd0, data_out}, 32'd0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    chk("restart_cmd", {31'd0, cmd_seq}, 32'd1);
    cyc(1'b1, 1'b0);
    chk("restart_first_lamp", {24'd0, data_out}, 32'h01);

    // Asynchronous reset while data_out = 0x0F
    repeat (3) cyc(1'b1, 1'b0);
    chk("pre_rst_data", {24'd0, data_out}, 32'h0F);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_data", {24'd0, data_out}, 32'd0);
    chk("async_rst_cmd", {31'd0, cmd_seq}, 32'd0);
    chk("async_rst_rtime", {16'd0, react_time}, 32'd0);
    chk("async_rst_pulses", {30'd0, react_valid, false_start}, 32'd0);
    @(negedge clk);
    cyc(1'b0, 1'b0);
    rst = 1'b0;
    cyc(1'b1, 1'b0);
    chk("post_rst_idle", {31'd0, cmd_seq}, 32'd0);

    // Trigger held high throughout: one sequence, no completion
    cyc(1'b0, 1'b1);
    chk("held_start_cmd", {31'd0, cmd_seq}, 32'd1);
    repeat (8) cyc(1'b1, 1'b1);
    chk("held_full_data", {24'd0, data_out}, 32'hFF);
    h = int'(lfsr_prev);
    hold_phase(h, 1, 1'b1);
    push_ev(1'b0, 16'd10);
    repeat (10) cyc(1'b1, 1'b1);
    chk("held_react_data", {24'd0, data_out}, 32'd0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    chk("held_done_rtime", {16'd0, react_time}, 32'd10);
    repeat (2) cyc(1'b0, 1'b0);

    chk("sb_empty", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
